// File: rtl/cpu_ctrl_pkg.sv
`default_nettype none
// =============================================================================
// Module  : cpu_ctrl_pkg
// Brief   : Opcodes, ALU codes, sequencer state codes and instruction classes
// Rev     : 1.0  initial release
// =============================================================================
package cpu_ctrl_pkg;

   localparam int STATE_W = 6;

   localparam logic [4:0] OP_LD   = 5'b00000, OP_LDI  = 5'b00001, OP_ST   = 5'b00010,
                          OP_ADD  = 5'b00011, OP_SUB  = 5'b00100, OP_AND  = 5'b00101,
                          OP_OR   = 5'b00110, OP_ROR  = 5'b00111, OP_ROL  = 5'b01000,
                          OP_SHR  = 5'b01001, OP_SHRA = 5'b01010, OP_SHL  = 5'b01011,
                          OP_ADDI = 5'b01100, OP_ANDI = 5'b01101, OP_ORI  = 5'b01110,
                          OP_DIV  = 5'b01111, OP_MUL  = 5'b10000, OP_NEG  = 5'b10001,
                          OP_NOT  = 5'b10010, OP_BR   = 5'b10011, OP_JAL  = 5'b10100,
                          OP_JR   = 5'b10101, OP_IN   = 5'b10110, OP_OUT  = 5'b10111,
                          OP_MFLO = 5'b11000, OP_MFHI = 5'b11001, OP_NOP  = 5'b11010,
                          OP_HALT = 5'b11011;

   localparam logic [4:0] ALU_ADD = OP_ADD, ALU_SUB = OP_SUB, ALU_AND = OP_AND,
                          ALU_OR  = OP_OR,  ALU_ROR = OP_ROR, ALU_ROL = OP_ROL,
                          ALU_SHR = OP_SHR, ALU_SHRA = OP_SHRA, ALU_SHL = OP_SHL,
                          ALU_DIV = OP_DIV, ALU_MUL = OP_MUL, ALU_NEG = OP_NEG,
                          ALU_NOT = OP_NOT;

   // T-states are consecutive so an execute step advances by +1
   localparam logic [STATE_W-1:0] S_RESET = 6'd0,  S_T0 = 6'd1, S_T1 = 6'd2, S_T2 = 6'd3,
                                  S_T3    = 6'd4,  S_T4 = 6'd5, S_T5 = 6'd6, S_T6 = 6'd7,
                                  S_T7    = 6'd8,  S_HALT = 6'd9, S_STOPPED = 6'd10;

   typedef struct packed {
      logic alur, alui, muldiv, unary, ld, ldi, st, br;
      logic jr, jal, io_in, io_out, mflo, mfhi, nop, halt;
   } instr_class_t;

   function automatic logic [STATE_W-1:0] last_step(input instr_class_t c);
      if (c.ld | c.st)                return S_T7;
      if (c.muldiv | c.br)            return S_T6;
      if (c.alur | c.alui | c.ldi)    return S_T5;
      if (c.unary | c.jal)            return S_T4;
      return S_T3;
   endfunction

endpackage
`default_nettype wire

// File: rtl/control_sequencer_if.sv
`default_nettype none
// =============================================================================
// Module  : control_sequencer_if
// Brief   : Control bus between the sequencer (master) and new_datapath (slave)
// Rev     : 1.0  initial release
// =============================================================================
interface control_sequencer_if;
   logic [31:0] IR;
   logic        CONout, Stop, Run;
   logic        PCout, PCin, PCinc, MARin, MDRin, MDRout, Read, write, IRin;
   logic        Yin, Zin, Zhiout, Zloout, HIin, HIout, LOin, LOout;
   logic        Gra, Grb, Grc, Rout, Rin, BAout, Cout, CONin, OUT_portin, IN_portout;
   logic [4:0]  ALUControl;

   modport master (
      input  IR, CONout, Stop,
      output Run, PCout, PCin, PCinc, MARin, MDRin, MDRout, Read, write, IRin,
             Yin, Zin, Zhiout, Zloout, HIin, HIout, LOin, LOout,
             Gra, Grb, Grc, Rout, Rin, BAout, Cout, CONin, OUT_portin, IN_portout,
             ALUControl
   );

   modport slave (
      output IR, CONout, Stop,
      input  Run, PCout, PCin, PCinc, MARin, MDRin, MDRout, Read, write, IRin,
             Yin, Zin, Zhiout, Zloout, HIin, HIout, LOin, LOout,
             Gra, Grb, Grc, Rout, Rin, BAout, Cout, CONin, OUT_portin, IN_portout,
             ALUControl
   );
endinterface
`default_nettype wire

// File: rtl/control_sequencer_decode.sv
`default_nettype none
// =============================================================================
// Module  : instr_class_decode
// Brief   : Opcode to one-hot instruction class and T4 ALU operation
// Rev     : 1.0  initial release
// =============================================================================
module instr_class_decode
   import cpu_ctrl_pkg::*;
(
   input  logic [4:0]   opcode,
   output instr_class_t cls,
   output logic [4:0]   alu_ctrl
);

   always_comb begin
      cls      = '0;
      alu_ctrl = 5'b00000;
      case (opcode)
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL, OP_SHR, OP_SHRA, OP_SHL: begin
            cls.alur = 1'b1;
            alu_ctrl = opcode;
         end
         OP_ADDI: begin cls.alui = 1'b1; alu_ctrl = ALU_ADD; end
         OP_ANDI: begin cls.alui = 1'b1; alu_ctrl = ALU_AND; end
         OP_ORI:  begin cls.alui = 1'b1; alu_ctrl = ALU_OR;  end
         OP_MUL, OP_DIV: begin cls.muldiv = 1'b1; alu_ctrl = opcode; end
         OP_NEG, OP_NOT: begin cls.unary  = 1'b1; alu_ctrl = opcode; end
         // address and branch-target arithmetic all use the adder
         OP_LD:   begin cls.ld  = 1'b1; alu_ctrl = ALU_ADD; end
         OP_LDI:  begin cls.ldi = 1'b1; alu_ctrl = ALU_ADD; end
         OP_ST:   begin cls.st  = 1'b1; alu_ctrl = ALU_ADD; end
         OP_BR:   begin cls.br  = 1'b1; alu_ctrl = ALU_ADD; end
         OP_JR:   cls.jr     = 1'b1;
         OP_JAL:  cls.jal    = 1'b1;
         OP_IN:   cls.io_in  = 1'b1;
         OP_OUT:  cls.io_out = 1'b1;
         OP_MFLO: cls.mflo   = 1'b1;
         OP_MFHI: cls.mfhi   = 1'b1;
         OP_HALT: cls.halt   = 1'b1;
         default: cls.nop    = 1'b1;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/control_sequencer.sv
`default_nettype none
// =============================================================================
// Module  : control_sequencer
// Brief   : Hardwired fetch/decode/execute control unit for new_datapath
// Rev     : 1.0  initial release
// =============================================================================
module control_sequencer
   import cpu_ctrl_pkg::*;
(
   input  logic               Clock,
   input  logic               GlobalReset,
   control_sequencer_if.master bus
);

   logic [STATE_W-1:0] r_state, w_next, w_to_t0;
   logic               r_held;
   instr_class_t       r_cls, w_cls;
   logic [4:0]         r_alu, w_alu;
   logic               w_addr;

   instr_class_decode u_decode (
      .opcode   (bus.IR[31:27]),
      .cls      (w_cls),
      .alu_ctrl (w_alu)
   );

   // Stop only takes effect at an instruction boundary
   assign w_to_t0 = bus.Stop ? S_STOPPED : S_T0;

   always_comb begin
      w_next = S_RESET;
      case (r_state)
         S_RESET:   w_next = r_held ? S_RESET : w_to_t0;
         S_T0:      w_next = S_T1;
         S_T1:      w_next = S_T2;
         S_T2:      w_next = w_cls.halt ? S_HALT : S_T3;
         S_T3, S_T4, S_T5, S_T6, S_T7:
                    w_next = (r_state == last_step(r_cls)) ? w_to_t0 : r_state + STATE_W'(1);
         S_HALT:    w_next = S_HALT;
         S_STOPPED: w_next = bus.Stop ? S_STOPPED : S_T0;
         default:   w_next = S_RESET;
      endcase
   end

   // r_held marks cycles whose preceding edge saw reset; Run stays low there
   always_ff @(posedge Clock) begin
      if (GlobalReset) begin
         r_state <= S_RESET;
         r_held  <= 1'b1;
         r_cls   <= '0;
         r_alu   <= 5'b00000;
      end else begin
         r_state <= w_next;
         r_held  <= 1'b0;
         if (r_state == S_T2) begin
            r_cls <= w_cls;
            r_alu <= w_alu;
         end
      end
   end

   assign bus.Run = ~r_held & (r_state != S_HALT) & (r_state != S_STOPPED);
   assign w_addr  = r_cls.ld | r_cls.ldi | r_cls.st;

   always_comb begin
      {bus.PCout, bus.PCin, bus.PCinc, bus.MARin, bus.MDRin, bus.MDRout, bus.Read, bus.write,
       bus.IRin, bus.Yin, bus.Zin, bus.Zhiout, bus.Zloout, bus.HIin, bus.HIout, bus.LOin,
       bus.LOout, bus.Gra, bus.Grb, bus.Grc, bus.Rout, bus.Rin, bus.BAout, bus.Cout,
       bus.CONin, bus.OUT_portin, bus.IN_portout, bus.ALUControl} = '0;
      case (r_state)
         S_T0: begin bus.PCout = 1'b1; bus.MARin = 1'b1; bus.PCinc = 1'b1; end
         S_T1: begin bus.Read = 1'b1; bus.MDRin = 1'b1; end
         S_T2: begin bus.MDRout = 1'b1; bus.IRin = 1'b1; end
         S_T3: begin
            bus.Gra  = r_cls.muldiv | r_cls.br | r_cls.jr | r_cls.io_in | r_cls.io_out
                     | r_cls.mflo | r_cls.mfhi;
            bus.Grb  = r_cls.alur | r_cls.alui | r_cls.unary | w_addr | r_cls.jal;
            bus.Rout = r_cls.alur | r_cls.alui | r_cls.muldiv | r_cls.unary | r_cls.br
                     | r_cls.jr | r_cls.io_out;
            bus.Rin  = r_cls.jal | r_cls.io_in | r_cls.mflo | r_cls.mfhi;
            bus.Yin  = r_cls.alur | r_cls.alui | r_cls.muldiv | w_addr;
            bus.Zin        = r_cls.unary;
            bus.BAout      = w_addr;
            bus.CONin      = r_cls.br;
            bus.PCin       = r_cls.jr;
            bus.PCout      = r_cls.jal;
            bus.IN_portout = r_cls.io_in;
            bus.OUT_portin = r_cls.io_out;
            bus.LOout      = r_cls.mflo;
            bus.HIout      = r_cls.mfhi;
            if (r_cls.unary) bus.ALUControl = r_alu;
         end
         S_T4: begin
            bus.Gra    = r_cls.unary | r_cls.jal;
            bus.Grb    = r_cls.muldiv;
            bus.Grc    = r_cls.alur;
            bus.Rout   = r_cls.alur | r_cls.muldiv | r_cls.jal;
            bus.Rin    = r_cls.unary;
            bus.Zin    = r_cls.alur | r_cls.alui | r_cls.muldiv | w_addr;
            bus.Cout   = r_cls.alui | w_addr;
            bus.Zloout = r_cls.unary;
            bus.PCout  = r_cls.br;
            bus.Yin    = r_cls.br;
            bus.PCin   = r_cls.jal;
            if (r_cls.alur | r_cls.alui | r_cls.muldiv | w_addr) bus.ALUControl = r_alu;
         end
         S_T5: begin
            bus.Zloout = r_cls.alur | r_cls.alui | r_cls.muldiv | w_addr;
            bus.Gra    = r_cls.alur | r_cls.alui | r_cls.ldi;
            bus.Rin    = r_cls.alur | r_cls.alui | r_cls.ldi;
            bus.LOin   = r_cls.muldiv;
            bus.MARin  = r_cls.ld | r_cls.st;
            bus.Cout   = r_cls.br;
            bus.Zin    = r_cls.br;
            if (r_cls.br) bus.ALUControl = r_alu;
         end
         S_T6: begin
            bus.Zhiout = r_cls.muldiv;
            bus.HIin   = r_cls.muldiv;
            bus.Read   = r_cls.ld;
            bus.MDRin  = r_cls.ld | r_cls.st;
            bus.Gra    = r_cls.st;
            bus.Rout   = r_cls.st;
            // branch commits only when the CON flip-flop says taken
            bus.Zloout = r_cls.br & bus.CONout;
            bus.PCin   = r_cls.br & bus.CONout;
         end
         S_T7: begin
            bus.MDRout = r_cls.ld;
            bus.Gra    = r_cls.ld;
            bus.Rin    = r_cls.ld;
            bus.write  = r_cls.st;
         end
         default: ;
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_control_sequencer.sv
`default_nettype none
// =============================================================================
// Module  : tb_control_sequencer
// Brief   : Directed + random instruction streams checked against a per-cycle model
// Rev     : 1.0  initial release
// =============================================================================
module tb_control_sequencer;

   typedef logic [32:0] word_t;

   localparam word_t PCOUT  = 33'd1 << 0,  PCIN   = 33'd1 << 1,  PCINC  = 33'd1 << 2,
                     MARIN  = 33'd1 << 3,  MDRIN  = 33'd1 << 4,  MDROUT = 33'd1 << 5,
                     READ   = 33'd1 << 6,  WRITE  = 33'd1 << 7,  IRIN   = 33'd1 << 8,
                     YIN    = 33'd1 << 9,  ZIN    = 33'd1 << 10, ZHIOUT = 33'd1 << 11,
                     ZLOOUT = 33'd1 << 12, HIIN   = 33'd1 << 13, HIOUT  = 33'd1 << 14,
                     LOIN   = 33'd1 << 15, LOOUT  = 33'd1 << 16, GRA    = 33'd1 << 17,
                     GRB    = 33'd1 << 18, GRC    = 33'd1 << 19, ROUT   = 33'd1 << 20,
                     RIN    = 33'd1 << 21, BAOUT  = 33'd1 << 22, COUT   = 33'd1 << 23,
                     CONIN  = 33'd1 << 24, OUTPIN = 33'd1 << 25, INPOUT = 33'd1 << 26,
                     RUN    = 33'd1 << 27;

   logic  Clock;
   logic  GlobalReset;
   int    n_cmp = 0;
   int    n_err = 0;
   word_t expq[$];

   control_sequencer_if sbus ();

   control_sequencer dut (
      .Clock       (Clock),
      .GlobalReset (GlobalReset),
      .bus         (sbus)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached, compared %0d", n_cmp);
      $fatal(1, "watchdog");
   end

   function automatic word_t alu(input int code);
      return word_t'(code) << 28;
   endfunction

   function automatic word_t observe();
      return {sbus.ALUControl, sbus.Run, sbus.IN_portout, sbus.OUT_portin, sbus.CONin,
              sbus.Cout, sbus.BAout, sbus.Rin, sbus.Rout, sbus.Grc, sbus.Grb, sbus.Gra,
              sbus.LOout, sbus.LOin, sbus.HIout, sbus.HIin, sbus.Zloout, sbus.Zhiout,
              sbus.Zin, sbus.Yin, sbus.IRin, sbus.write, sbus.Read, sbus.MDRout,
              sbus.MDRin, sbus.MARin, sbus.PCinc, sbus.PCin, sbus.PCout};
   endfunction

   function automatic void step(input word_t w);
      expq.push_back(w | RUN);
   endfunction

   // Expected enable set for every cycle of one instruction, fetch included
   function automatic void model(input int op, input bit con);
      expq.delete();
      step(PCOUT | MARIN | PCINC);
      step(READ | MDRIN);
      step(MDROUT | IRIN);
      case (op)
         3, 4, 5, 6, 7, 8, 9, 10, 11: begin
            step(GRB | ROUT | YIN); step(GRC | ROUT | ZIN | alu(op)); step(ZLOOUT | GRA | RIN);
         end
         12, 13, 14: begin
            step(GRB | ROUT | YIN);
            step(COUT | ZIN | alu(op == 12 ? 3 : (op == 13 ? 5 : 6)));
            step(ZLOOUT | GRA | RIN);
         end
         15, 16: begin
            step(GRA | ROUT | YIN); step(GRB | ROUT | ZIN | alu(op));
            step(ZLOOUT | LOIN);    step(ZHIOUT | HIIN);
         end
         17, 18: begin step(GRB | ROUT | ZIN | alu(op)); step(ZLOOUT | GRA | RIN); end
         0, 1, 2: begin
            step(GRB | BAOUT | YIN); step(COUT | ZIN | alu(3));
            if (op == 1) step(ZLOOUT | GRA | RIN);
            else if (op == 0) begin
               step(ZLOOUT | MARIN); step(READ | MDRIN); step(MDROUT | GRA | RIN);
            end else begin
               step(ZLOOUT | MARIN); step(GRA | ROUT | MDRIN); step(WRITE);
            end
         end
         19: begin
            step(GRA | ROUT | CONIN); step(PCOUT | YIN); step(COUT | ZIN | alu(3));
            step(con ? (ZLOOUT | PCIN) : '0);
         end
         20: begin step(PCOUT | GRB | RIN); step(GRA | ROUT | PCIN); end
         21: step(GRA | ROUT | PCIN);
         22: step(INPOUT | GRA | RIN);
         23: step(GRA | ROUT | OUTPIN);
         24: step(LOOUT | GRA | RIN);
         25: step(HIOUT | GRA | RIN);
         27: ;
         default: step('0);
      endcase
   endfunction

   task automatic expect_cycle(input word_t exp, input string tag);
      word_t o;
      @(negedge Clock);
      o = observe();
      n_cmp++;
      assert (o === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, o, exp);
      end
      @(posedge Clock);
      #1;
   endtask

   // Two reset edges, one held cycle, one RESET cycle with Run=1; ends at T0
   task automatic do_reset();
      GlobalReset = 1'b1;
      sbus.Stop   = 1'b0;
      @(posedge Clock);
      #1;
      expect_cycle('0, "reset_hold");
      GlobalReset = 1'b0;
      expect_cycle('0, "reset_last");
      expect_cycle(RUN, "reset_run");
   endtask

   task automatic run_instr(input logic [31:0] ir, input bit con, input int stop_at,
                            input int abort_at);
      int op;
      op = int'(ir[31:27]);
      sbus.IR     = ir;
      sbus.CONout = con;
      model(op, con);
      for (int i = 0; i < expq.size(); i++) begin
         if (i == abort_at) begin
            do_reset();
            return;
         end
         expect_cycle(expq[i], $sformatf("op%05b_t%0d_con%0d", ir[31:27], i, con));
         if (i == stop_at && i < expq.size() - 1) sbus.Stop = 1'b1;
      end
      if (sbus.Stop) begin
         repeat ($urandom_range(1, 3)) expect_cycle('0, "stopped");
         sbus.Stop = 1'b0;
         expect_cycle('0, "stopped_release");
      end
   endtask

   initial begin
      logic [4:0] op;
      int         s_at, a_at;
      sbus.IR     = '0;
      sbus.CONout = 1'b0;
      sbus.Stop   = 1'b0;
      GlobalReset = 1'b1;
      do_reset();

      run_instr(32'h19890000, 1'b0, -1, -1);
      run_instr({5'b10101, 27'($urandom)}, 1'b0, -1, -1);
      run_instr({5'b10011, 27'($urandom)}, 1'b0, -1, -1);
      run_instr({5'b10011, 27'($urandom)}, 1'b1, -1, -1);
      run_instr({5'b00010, 27'($urandom)}, 1'b0, -1, -1);
      run_instr({5'b00000, 27'($urandom)}, 1'b0, -1, -1);
      run_instr(32'h19890000, 1'b0, 3, -1);
      run_instr({5'b00000, 27'($urandom)}, 1'b0, -1, 6);
      run_instr({5'b11111, 27'($urandom)}, 1'b0, -1, -1);

      for (int n = 0; n < 150; n++) begin
         op = 5'($urandom_range(0, 31));
         if (op == 5'd27) op = 5'd26;
         s_at = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 6)) : -1;
         a_at = ($urandom_range(0, 14) == 0) ? int'($urandom_range(1, 7)) : -1;
         run_instr({op, 27'($urandom)}, 1'($urandom_range(0, 1)), s_at, a_at);
      end

      run_instr({5'b11011, 27'($urandom)}, 1'b0, -1, -1);
      for (int n = 0; n < 20; n++) begin
         sbus.Stop = ~sbus.Stop;
         expect_cycle('0, "halted");
      end
      do_reset();
      run_instr(32'h19890000, 1'b0, -1, -1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
